// File: rtl/mem_write_post_pkg.sv
`timescale 1ns/1ps
// mem_write_post_pkg: shared types and constants for the write-posting buffer.
package mem_write_post_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } post_state_t;

    // Byte-enable pattern for each byte lane (index = byte address bit 0)
    localparam logic [1:0] LANE_BYTE_EN [2] = '{2'b01, 2'b10};

    // FIFO entry layout, MSB to LSB: {word addr, byte, lane}
    localparam int ENTRY_DATA_W = 8;

    function automatic int entry_width(input int addr_w);
        return addr_w + ENTRY_DATA_W + 1;
    endfunction

endpackage

// File: rtl/mem_port_if.sv
`timescale 1ns/1ps
// mem_port_if: one SDRAM controller memory port (client drives requests).
interface mem_port_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int DQM_WIDTH  = 2
);
    logic                  wr;
    logic                  rd;
    logic                  burst;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DQM_WIDTH-1:0]  byte_en;
    logic [DATA_WIDTH-1:0] q;
    logic                  available;
    logic                  ready;

    modport client (output wr, rd, burst, addr, data, byte_en,
                    input  q, available, ready);
    modport ctrl   (input  wr, rd, burst, addr, data, byte_en,
                    output q, available, ready);
endinterface

// File: rtl/mem_write_post_fifo_fifo.sv
`timescale 1ns/1ps
// post_fifo: synchronous FIFO with RAM storage and a registered head entry.
// head_next_o exposes the entry behind the head so a pop can reload at once.
module post_fifo #(
    parameter int WIDTH      = 21,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  pop_i,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic [DEPTH_LOG2:0]   count_next_o,
    output logic [WIDTH-1:0]      head_o,
    output logic [WIDTH-1:0]      head_next_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_ZERO = '0;
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);

    logic [WIDTH-1:0]      ram_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [WIDTH-1:0]      head_q, head_d;
    logic                  do_pop;

    assign do_pop      = pop_i && (count_q != CNT_ZERO);
    assign head_next_o = ram_q[rd_ptr_q + 1'b1];

    // Pointer, occupancy and head next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (do_pop && (count_q > CNT_ONE)) begin
            head_d = head_next_o;
        end else if (push_i && ((count_q == CNT_ZERO) || (do_pop && (count_q == CNT_ONE)))) begin
            // Queue is (or becomes) empty: the incoming entry is the new head
            head_d = data_i;
        end
    end

    // Storage write; no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (push_i) ram_q[wr_ptr_q] <= data_i;
    end

    // Control and head registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign head_o       = head_q;
endmodule

// File: rtl/mem_write_post_fifo.sv
`timescale 1ns/1ps
// mem_write_post_fifo: posts unstallable byte writes into a FIFO and drains
// them as masked 16-bit writes on a memory port.
// Optional statistics outputs (drop_count_o, high_water_o) are built when
// MEM_WRITE_POST_STATS_EN is defined.
module mem_write_post_fifo
    import mem_write_post_pkg::*;
#(
    parameter int PORT_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH      = 16,
    parameter int DQM_WIDTH       = 2,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid_i,
    input  logic [PORT_ADDR_WIDTH:0]   wr_addr_i,
    input  logic [7:0]                 wr_data_i,
    output logic                       overflow_o,
    output logic                       busy_o,
`ifdef MEM_WRITE_POST_STATS_EN
    output logic [15:0]                drop_count_o,
    output logic [FIFO_DEPTH_LOG2:0]   high_water_o,
`endif
    mem_port_if.client                 mem
);
    localparam int ENTRY_W = entry_width(PORT_ADDR_WIDTH);
    localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] CNT_DEPTH = (FIFO_DEPTH_LOG2+1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0] CNT_ONE   = (FIFO_DEPTH_LOG2+1)'(1);
    localparam logic [FIFO_DEPTH_LOG2:0] CNT_ZERO  = '0;

    post_state_t                state_q, state_d;
    logic                       wr_q, wr_d;
    logic [PORT_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic [DQM_WIDTH-1:0]       be_q, be_d;
    logic                       ovf_q, busy_q, busy_d;

    logic                       push, pop, drop, room;
    logic                       load_en;
    logic [ENTRY_W-1:0]         load_e, entry_in;
    logic [ENTRY_W-1:0]         fifo_head, fifo_head_next;
    logic [FIFO_DEPTH_LOG2:0]   fifo_count, fifo_count_next;

    assign entry_in = {wr_addr_i[PORT_ADDR_WIDTH:1], wr_data_i, wr_addr_i[0]};
    // A full queue still takes a write when the head leaves in the same cycle
    assign room     = (fifo_count < CNT_DEPTH) || pop;
    assign push     = wr_valid_i && room;
    assign drop     = wr_valid_i && !room;
    assign busy_d   = (fifo_count_next != CNT_ZERO) || (state_d != IDLE);

    post_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .data_i       (entry_in),
        .pop_i        (pop),
        .count_o      (fifo_count),
        .count_next_o (fifo_count_next),
        .head_o       (fifo_head),
        .head_next_o  (fifo_head_next)
    );

    // Drain FSM: issue head, wait for acceptance, then for completion
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        pop     = 1'b0;
        load_en = 1'b0;
        load_e  = fifo_head;
        case (state_q)
            IDLE: begin
                if (fifo_count != CNT_ZERO) begin
                    load_en = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem.available) begin
                    wr_d    = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem.ready) begin
                    pop = 1'b1;
                    if (fifo_count > CNT_ONE) begin
                        load_e  = fifo_head_next;
                        load_en = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_en) begin
            wr_d   = 1'b1;
            addr_d = load_e[ENTRY_W-1:ENTRY_DATA_W+1];
            data_d = {(DATA_WIDTH/8){load_e[ENTRY_DATA_W:1]}};
            be_d   = LANE_BYTE_EN[load_e[0]];
        end
    end

    // State, port drive, overflow pulse and busy flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            ovf_q   <= drop;
            busy_q  <= busy_d;
        end
    end

`ifdef MEM_WRITE_POST_STATS_EN
    logic [15:0]              drop_cnt_q;
    logic [FIFO_DEPTH_LOG2:0] high_q;

    // Saturating drop counter and peak occupancy since reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            high_q     <= '0;
        end else begin
            if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
            if (fifo_count_next > high_q) high_q <= fifo_count_next;
        end
    end

    assign drop_count_o = drop_cnt_q;
    assign high_water_o = high_q;
`endif

    assign mem.wr      = wr_q;
    assign mem.rd      = 1'b0;
    assign mem.burst   = 1'b0;
    assign mem.addr    = addr_q;
    assign mem.data    = data_q;
    assign mem.byte_en = be_q;
    assign overflow_o  = ovf_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_mem_write_post_fifo.sv
`timescale 1ns/1ps
// Bench for mem_write_post_fifo: a directed vector table, directed corner
// sequences, and randomized traffic scored against a queue-based model.
module tb_mem_write_post_fifo;
    localparam int AW    = 12;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [AW:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        overflow, busy;
`ifdef MEM_WRITE_POST_STATS_EN
    logic [15:0] drop_count;
    logic [4:0]  high_water;
`endif

    mem_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(16), .DQM_WIDTH(2)) mem_if ();

    mem_write_post_fifo #(
        .PORT_ADDR_WIDTH (AW),
        .DATA_WIDTH      (16),
        .DQM_WIDTH       (2),
        .FIFO_DEPTH_LOG2 (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid_i   (wr_valid),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .overflow_o   (overflow),
        .busy_o       (busy),
`ifdef MEM_WRITE_POST_STATS_EN
        .drop_count_o (drop_count),
        .high_water_o (high_water),
`endif
        .mem          (mem_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [12:0] a;
        logic [7:0]  d;
        logic        av;
        logic        rd;
        logic        e_wr;
        logic        e_chk;
        logic [11:0] e_addr;
        logic [15:0] e_data;
        logic [1:0]  e_be;
        logic        e_busy;
    } vec_t;
    vec_t tbl [11];

    // ---------------- behavioural model ----------------
    typedef struct packed { logic [12:0] a; logic [7:0] d; } ent_t;
    ent_t mq[$];
    int   acc_t[$];
    bit   pending, exp_ovf, chk_fp;
    int   rcnt, lat, avail_pct, spur_pct, cyc, ovf_seen, drops_m, hw_m;

    task automatic do_reset();
        rst_n = 1'b0;
        wr_valid = 1'b0;
        mem_if.available = 1'b0;
        mem_if.ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        acc_t.delete();
        pending = 0; exp_ovf = 0; chk_fp = 0;
        ovf_seen = 0; drops_m = 0; hw_m = 0; cyc = 0;
    endtask

    // One clock: check DUT against the model, then choose and apply inputs.
    task automatic cycle(input logic v, input logic [12:0] a, input logic [7:0] d);
        logic av, rdy, pop, acc, ok;
        int   pre;
        ent_t e;
        chk("busy", busy, mq.size() != 0);
        chk("overflow", overflow, exp_ovf);
        if (chk_fp) chk("full_pop_push_no_ovf", overflow, 1'b0);
        if (overflow) ovf_seen++;
        if (mem_if.wr) begin
            chk("wr_during_wait", pending, 1'b0);
            if (mq.size() == 0) begin
                chk("wr_with_empty_queue", mem_if.wr, 1'b0);
            end else begin
                e = mq[0];
                chk("addr", mem_if.addr, e.a[12:1]);
                chk("data", mem_if.data, {e.d, e.d});
                chk("byte_en", mem_if.byte_en, e.a[0] ? 2'b10 : 2'b01);
            end
        end
        av  = ($urandom_range(99) < avail_pct);
        rdy = 1'b0;
        if (pending) begin
            if (rcnt == 0) rdy = 1'b1;
            else rcnt--;
        end else if ($urandom_range(99) < spur_pct) begin
            rdy = 1'b1;
        end
        pre     = mq.size();
        pop     = pending && rdy;
        acc     = mem_if.wr && av && !pending;
        ok      = v && (pre < DEPTH || pop);
        exp_ovf = v && !ok;
        chk_fp  = pop && v && (pre == DEPTH);
        if (exp_ovf) drops_m++;
        if (pop) begin
            void'(mq.pop_front());
            pending = 0;
        end
        if (ok) begin
            e.a = a; e.d = d;
            mq.push_back(e);
        end
        if (mq.size() > hw_m) hw_m = mq.size();
        if (acc) begin
            pending = 1;
            rcnt = (lat < 0) ? $urandom_range(3) : lat;
            acc_t.push_back(cyc);
        end
        cyc++;
        wr_valid = v; wr_addr = a; wr_data = d;
        mem_if.available = av;
        mem_if.ready = rdy;
        @(negedge clk);
    endtask

    task automatic drain(input int bound);
        for (int k = 0; k < bound && (mq.size() != 0 || pending); k++) cycle(1'b0, '0, '0);
        cycle(1'b0, '0, '0);
        chk("busy_after_drain", busy, 1'b0);
    endtask

    initial begin
        mem_if.available = 1'b0;
        mem_if.ready = 1'b0;
        mem_if.q = '0;
        lat = 0; avail_pct = 100; spur_pct = 0;

        tbl[0]  = '{1'b1, 13'h14B, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 2'b00, 1'b1};
        tbl[1]  = '{1'b0, 13'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 12'h0A5, 16'h3C3C, 2'b10, 1'b1};
        tbl[2]  = '{1'b0, 13'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 2'b00, 1'b1};
        tbl[3]  = '{1'b0, 13'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 2'b00, 1'b0};
        tbl[4]  = '{1'b0, 13'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 2'b00, 1'b0};
        tbl[5]  = '{1'b1, 13'h002, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 2'b00, 1'b1};
        tbl[6]  = '{1'b0, 13'h000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 12'h001, 16'hA5A5, 2'b01, 1'b1};
        tbl[7]  = '{1'b0, 13'h000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 12'h001, 16'hA5A5, 2'b01, 1'b1};
        tbl[8]  = '{1'b0, 13'h000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 2'b00, 1'b1};
        tbl[9]  = '{1'b0, 13'h000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 2'b00, 1'b1};
        tbl[10] = '{1'b0, 13'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 2'b00, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_wr", mem_if.wr, 1'b0);
        chk("rst_rd", mem_if.rd, 1'b0);
        chk("rst_burst", mem_if.burst, 1'b0);
        chk("rst_addr", mem_if.addr, 12'h000);
        chk("rst_data", mem_if.data, 16'h0000);
        chk("rst_byte_en", mem_if.byte_en, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
`ifdef MEM_WRITE_POST_STATS_EN
        chk("rst_drop_count", drop_count, 16'd0);
        chk("rst_high_water", high_water, 5'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Table: single writes on both lanes, ready/available ignored outside their states
        for (int i = 0; i < 11; i++) begin
            wr_valid = tbl[i].v; wr_addr = tbl[i].a; wr_data = tbl[i].d;
            mem_if.available = tbl[i].av; mem_if.ready = tbl[i].rd;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_wr", i), mem_if.wr, tbl[i].e_wr);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_ovf", i), overflow, 1'b0);
            if (tbl[i].e_chk) begin
                chk($sformatf("tbl%0d_addr", i), mem_if.addr, tbl[i].e_addr);
                chk($sformatf("tbl%0d_data", i), mem_if.data, tbl[i].e_data);
                chk($sformatf("tbl%0d_be", i), mem_if.byte_en, tbl[i].e_be);
            end
            @(negedge clk);
        end
        wr_valid = 1'b0; mem_if.available = 1'b0; mem_if.ready = 1'b0;

        // 17 writes with the port blocked: 16 queued, one dropped, drained in order
        do_reset();
        avail_pct = 0; lat = 0; spur_pct = 0;
        for (int i = 0; i < 17; i++) cycle(1'b1, 13'(i * 37 + 1), 8'(8'h10 + i));
        cycle(1'b0, '0, '0);
        cycle(1'b0, '0, '0);
        chk("ovf_pulses_17", ovf_seen, 1);
        acc_t.delete();
        avail_pct = 100;
        drain(200);
        chk("drained_count", acc_t.size(), 16);

        // Full queue with a push in the same cycle as a pop
        do_reset();
        avail_pct = 0;
        for (int i = 0; i < 16; i++) cycle(1'b1, 13'($urandom), 8'($urandom));
        avail_pct = 100;
        for (int i = 0; i < 30; i++) cycle(1'b1, 13'($urandom), 8'($urandom));
        drain(300);

        // Ready three cycles after acceptance: one write every five cycles
        do_reset();
        avail_pct = 0; lat = 3;
        for (int i = 0; i < 6; i++) cycle(1'b1, 13'($urandom), 8'($urandom));
        acc_t.delete();
        avail_pct = 100;
        drain(200);
        chk("period_accepts", acc_t.size(), 6);
        for (int i = 1; i < acc_t.size(); i++) chk($sformatf("period_%0d", i), acc_t[i] - acc_t[i-1], 5);

        // Reset in WAIT with 5 queued, then a spurious ready
        do_reset();
        avail_pct = 0; lat = 50;
        for (int i = 0; i < 5; i++) cycle(1'b1, 13'($urandom), 8'($urandom));
        avail_pct = 100;
        for (int k = 0; k < 20 && !pending; k++) cycle(1'b0, '0, '0);
        cycle(1'b0, '0, '0);
        do_reset();
        spur_pct = 100; avail_pct = 100; lat = 0;
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0);
        chk("busy_after_reset", busy, 1'b0);
        chk("wr_after_reset", mem_if.wr, 1'b0);
        spur_pct = 0;

`ifdef MEM_WRITE_POST_STATS_EN
        // Statistics: fill to 16, drop 3
        do_reset();
        avail_pct = 0;
        for (int i = 0; i < 19; i++) cycle(1'b1, 13'($urandom), 8'($urandom));
        cycle(1'b0, '0, '0);
        chk("drop_count", drop_count, 16'd3);
        chk("high_water", high_water, 5'd16);
        chk("drop_count_model", drop_count, drops_m);
        chk("high_water_model", high_water, hw_m);
        avail_pct = 100; lat = 0;
        drain(200);
`endif

        // Randomized traffic
        do_reset();
        avail_pct = 60; spur_pct = 10; lat = -1;
        for (int i = 0; i < 1500; i++)
            cycle(($urandom_range(99) < 50), 13'($urandom), 8'($urandom));
        avail_pct = 100; spur_pct = 0;
        drain(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end
endmodule
